// File: rtl/live_window_gen.sv
// Spill window generator: LIVE gate with an early-falling trigger enable (TENA),
// one-shot or periodic, with abort, retrigger, spill counting and start/end strobes.
module live_window_gen #(
    parameter int LEN_W     = 8,
    parameter int UNIT_LOG2 = 23,
    parameter int SPILL_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_start,
    input  logic               in_abort,
    input  logic               user_mode,
    input  logic [LEN_W-1:0]   user_length,
    input  logic [LEN_W-1:0]   user_guard,
    input  logic [LEN_W-1:0]   user_gap,
    output logic               out_live,
    output logic               out_tena,
    output logic               out_busy,
    output logic               out_sot,
    output logic               out_eot,
    output logic [SPILL_W-1:0] out_spill_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LIVE  = 2'd1,
        S_GUARD = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [UNIT_LOG2-1:0] PRE_ONE   = UNIT_LOG2'(1);
    localparam logic [LEN_W-1:0]     UNIT_ONE  = LEN_W'(1);
    localparam logic [SPILL_W-1:0]   SPILL_ONE = SPILL_W'(1);

    state_t               state, next_state, exit_state;
    logic [UNIT_LOG2-1:0] pre;
    logic [LEN_W-1:0]     ucnt;
    logic [LEN_W-1:0]     term;
    logic                 cfg_mode;
    logic [LEN_W-1:0]     cfg_len, cfg_guard, cfg_gap;
    logic                 unit_tick, unit_last, start_ok, enter, sot_n, next_live;

    assign unit_tick  = &pre;
    assign unit_last  = unit_tick && (ucnt == term);
    assign start_ok   = in_start && (user_length != '0) && !in_abort;
    assign exit_state = cfg_mode ? S_GAP : S_IDLE;
    assign next_live  = (next_state == S_LIVE) || (next_state == S_GUARD);

    // Terminal unit index of the current state (durations are counted in units).
    always_comb begin
        term = '0;
        case (state)
            S_LIVE:  term = cfg_len - UNIT_ONE;
            S_GUARD: term = cfg_guard - UNIT_ONE;
            S_GAP:   term = (cfg_gap == '0) ? '0 : cfg_gap - UNIT_ONE;
            default: term = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        enter      = 1'b0;
        sot_n      = 1'b0;
        case (state)
            S_LIVE: if (unit_last) begin
                next_state = (cfg_guard != '0) ? S_GUARD : exit_state;
                enter      = 1'b1;
            end
            S_GUARD: if (unit_last) begin
                next_state = exit_state;
                enter      = 1'b1;
            end
            S_GAP: if (unit_last) begin
                next_state = S_LIVE;
                enter      = 1'b1;
                sot_n      = 1'b1;
            end
            default: ;
        endcase
        if (start_ok) begin
            next_state = S_LIVE;
            enter      = 1'b1;
            sot_n      = 1'b1;
        end
        // Abort overrides everything, including a simultaneous start.
        if (in_abort) begin
            next_state = S_IDLE;
            enter      = 1'b1;
            sot_n      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pre           <= '0;
            ucnt          <= '0;
            cfg_mode      <= 1'b0;
            cfg_len       <= '0;
            cfg_guard     <= '0;
            cfg_gap       <= '0;
            out_live      <= 1'b0;
            out_tena      <= 1'b0;
            out_busy      <= 1'b0;
            out_sot       <= 1'b0;
            out_eot       <= 1'b0;
            out_spill_cnt <= '0;
        end else begin
            state <= next_state;
            if (enter || next_state == S_IDLE) begin
                pre  <= '0;
                ucnt <= '0;
            end else begin
                pre <= pre + PRE_ONE;
                if (unit_tick) ucnt <= ucnt + UNIT_ONE;
            end
            if (start_ok) begin
                cfg_mode  <= user_mode;
                cfg_len   <= user_length;
                cfg_guard <= user_guard;
                cfg_gap   <= user_gap;
            end
            out_live <= next_live;
            out_tena <= (next_state == S_LIVE);
            out_busy <= (next_state != S_IDLE);
            out_sot  <= sot_n;
            out_eot  <= out_live && !next_live;
            if (sot_n) out_spill_cnt <= out_spill_cnt + SPILL_ONE;
        end
    end

endmodule

// File: tb/tb_live_window_gen.sv
// Directed bench for live_window_gen with UNIT_LOG2=2 (4-cycle units) and a 4-bit spill counter.
module tb_live_window_gen;

    localparam int LEN_W = 8;
    localparam int SPILL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_start, in_abort, user_mode;
    logic [LEN_W-1:0]   user_length, user_guard, user_gap;
    logic               out_live, out_tena, out_busy, out_sot, out_eot;
    logic [SPILL_W-1:0] out_spill_cnt;

    int checks = 0;
    int errors = 0;
    logic [SPILL_W-1:0] exp_spill = '0;
    logic [4:0] obs, exp;

    live_window_gen #(.LEN_W(LEN_W), .UNIT_LOG2(2), .SPILL_W(SPILL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_abort(in_abort),
        .user_mode(user_mode), .user_length(user_length), .user_guard(user_guard),
        .user_gap(user_gap), .out_live(out_live), .out_tena(out_tena),
        .out_busy(out_busy), .out_sot(out_sot), .out_eot(out_eot),
        .out_spill_cnt(out_spill_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {out_live, out_tena, out_sot, out_eot, out_busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic mode, input int l, input int g, input int p);
        user_mode = mode; user_length = LEN_W'(l); user_guard = LEN_W'(g); user_gap = LEN_W'(p);
        in_start = 1'b1;
        step();
        in_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_start = 1'b0; in_abort = 1'b0; user_mode = 1'b0;
        user_length = '0; user_guard = '0; user_gap = '0;
        repeat (3) step();
        checks++;
        if (obs !== 5'b00000) begin
            errors++; $display("FAIL reset_outputs got %b want 00000", obs);
        end
        checks++;
        if (out_spill_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_spill got %0d want 0", out_spill_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_one_shot();
        pulse_start(1'b0, 3, 1, 0);
        exp_spill = exp_spill + 1'b1;
        // Changing inputs after start must not affect the running window.
        user_mode = 1'b1; user_length = 8'hff; user_guard = 8'h05;
        for (int rel = 1; rel <= 20; rel++) begin
            exp = {rel <= 16, rel <= 12, rel == 1, rel == 17, rel <= 16};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL one_shot rel=%0d got %b want %b", rel, obs, exp);
            end
            step();
        end
        checks++;
        if (out_spill_cnt !== exp_spill) begin
            errors++; $display("FAIL one_shot_spill got %0d want %0d", out_spill_cnt, exp_spill);
        end
    endtask

    task automatic test_periodic_abort();
        int r;
        pulse_start(1'b1, 1, 1, 2);
        user_mode = 1'b0;
        for (int rel = 1; rel <= 38; rel++) begin
            r = (rel - 1) % 16;
            exp = {r < 8, r < 4, r == 0, r == 8, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL periodic rel=%0d got %b want %b", rel, obs, exp);
            end
            in_abort = (rel == 38);
            step();
        end
        exp_spill = exp_spill + 4'd3;
        checks++;
        if (obs !== 5'b00010) begin
            errors++; $display("FAIL abort_guard got %b want 00010", obs);
        end
        in_abort = 1'b0;
        step();
        checks++;
        if (obs !== 5'b00000) begin
            errors++; $display("FAIL abort_after got %b want 00000", obs);
        end
        checks++;
        if (out_spill_cnt !== exp_spill) begin
            errors++; $display("FAIL periodic_spill got %0d want %0d", out_spill_cnt, exp_spill);
        end
    endtask

    task automatic test_retrigger();
        pulse_start(1'b0, 3, 1, 0);
        for (int rel = 1; rel <= 30; rel++) begin
            exp = {rel <= 26, rel <= 22, rel == 1 || rel == 11, rel == 27, rel <= 26};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL retrigger rel=%0d got %b want %b", rel, obs, exp);
            end
            in_start = (rel == 10);
            step();
        end
        in_start = 1'b0;
        exp_spill = exp_spill + 4'd2;
        checks++;
        if (out_spill_cnt !== exp_spill) begin
            errors++; $display("FAIL retrigger_spill got %0d want %0d", out_spill_cnt, exp_spill);
        end
    endtask

    task automatic test_zero_guard();
        pulse_start(1'b0, 2, 0, 0);
        exp_spill = exp_spill + 1'b1;
        user_length = '0;
        for (int rel = 1; rel <= 12; rel++) begin
            exp = {rel <= 8, rel <= 8, rel == 1, rel == 9, rel <= 8};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL zero_guard rel=%0d got %b want %b", rel, obs, exp);
            end
            in_start = (rel == 4 || rel == 10);
            step();
        end
        in_start = 1'b0;
        checks++;
        if (out_spill_cnt !== exp_spill) begin
            errors++; $display("FAIL zero_len_spill got %0d want %0d", out_spill_cnt, exp_spill);
        end
    endtask

    task automatic test_abort_start();
        pulse_start(1'b0, 3, 1, 0);
        exp_spill = exp_spill + 1'b1;
        for (int rel = 1; rel <= 6; rel++) begin
            exp = {rel <= 3, rel <= 3, rel == 1, rel == 4, rel <= 3};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL abort_start rel=%0d got %b want %b", rel, obs, exp);
            end
            in_start = (rel == 3);
            in_abort = (rel == 3 || rel == 4);
            step();
        end
        in_start = 1'b0; in_abort = 1'b0;
        checks++;
        if (out_spill_cnt !== exp_spill) begin
            errors++; $display("FAIL abort_start_spill got %0d want %0d", out_spill_cnt, exp_spill);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(1'b1, 3, 1, 1);
        for (int rel = 1; rel <= 5; rel++) begin
            exp = {rel <= 3, rel <= 3, rel == 1, 1'b0, rel <= 3};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL reset_mid rel=%0d got %b want %b", rel, obs, exp);
            end
            rst_n = (rel != 3);
            step();
        end
        exp_spill = '0;
        checks++;
        if (out_spill_cnt !== exp_spill) begin
            errors++; $display("FAIL reset_mid_spill got %0d want 0", out_spill_cnt);
        end
    endtask

    task automatic test_spill_wrap();
        for (int i = 0; i < 17; i++) begin
            pulse_start(1'b0, 1, 0, 0);
            exp_spill = exp_spill + 1'b1;
            repeat (5) step();
            checks++;
            if (out_spill_cnt !== exp_spill) begin
                errors++; $display("FAIL spill_wrap n=%0d got %0d want %0d", i + 1, out_spill_cnt, exp_spill);
            end
        end
        checks++;
        if (out_spill_cnt !== 4'd1) begin
            errors++; $display("FAIL spill_wrap_final got %0d want 1", out_spill_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic_abort();
        test_retrigger();
        test_zero_guard();
        test_abort_start();
        test_reset_mid();
        test_spill_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
